stitch_wr_scheduler: RTL and testbench

Parametrised N-channel write scheduler for the video stitching datapath, clocked in the AXI domain. It arbitrates between per-camera write FIFOs, tracks each channel's line and burst position, and generates the DDR burst address of each channel's tile inside the stitched output frame. It rotates a ring of NUM_BUF frame buffers and publishes the latest completed buffer to the read/display side. It generalises the fixed 3-camera layout to NUM_CH channels with arbitrary burst-aligned tile placement and multi-buffering.

---
 rtl/stitch_pkg.sv | 35 +++
 rtl/stitch_rr_arbiter.sv | 48 ++++
 rtl/stitch_wr_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_stitch_wr_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stitch_pkg.sv
//==== stitch_pkg: shared types, default tile layout and burst address helper ====
//==== Rev 1.0 ====
`default_nettype none

package stitch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam int unsigned PIX_BYTES = 4;
    localparam int unsigned CNT_W     = 16;

    // Index 0 is the rightmost element: channel 0 owns the left full-height tile.
    localparam logic [2:0][31:0] DEF_X_OFF = {32'd960, 32'd960, 32'd0};
    localparam logic [2:0][31:0] DEF_Y_OFF = {32'd540, 32'd0,   32'd0};
    localparam logic [2:0][31:0] DEF_HSIZE = {32'd960, 32'd960, 32'd960};
    localparam logic [2:0][31:0] DEF_VSIZE = {32'd540, 32'd540, 32'd1080};

    function automatic logic [63:0] burst_addr(
        input logic [63:0] base,
        input logic [63:0] frame_bytes,
        input logic [63:0] stride,
        input logic [63:0] buf_idx,
        input logic [63:0] y_line,
        input logic [63:0] x_pix
    );
        return base + buf_idx * frame_bytes + y_line * stride + x_pix * 64'(PIX_BYTES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stitch_rr_arbiter.sv
//==== stitch_rr_arbiter: round-robin one-hot arbiter with explicit pointer update ====
//==== Rev 1.0 ====
`default_nettype none

module stitch_rr_arbiter #(
    parameter int unsigned NUM_CH = 3,
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              upd,
    input  logic [IW-1:0]     upd_idx,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     gnt_idx
);

    localparam int unsigned IW1 = IW + 1;

    logic [IW-1:0]     ptr;
    logic [IW-1:0]     sel;
    logic [NUM_CH-1:0] rot;
    logic [IW:0]       sum;

    // Rotate requests so the pointer lands on bit 0, pick lowest, rotate back.
    always_comb begin
        rot = NUM_CH'({req, req} >> ptr);
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) sel = IW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, sel};
        if (sum >= IW1'(NUM_CH)) sum = sum - IW1'(NUM_CH);
        gnt_idx = sum[IW-1:0];
        gnt     = (|req) ? (NUM_CH'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (upd_idx == IW'(NUM_CH - 1)) ? '0 : upd_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stitch_wr_scheduler.sv
//==== stitch_wr_scheduler: N-channel tile burst scheduler with frame buffer ring ====
//==== Rev 1.0 ====
`default_nettype none

module stitch_wr_scheduler
    import stitch_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned BURST_LEN   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned LINE_STRIDE = 7680,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES = ADDR_WIDTH'(32'h007E_9000),
    parameter int unsigned NUM_BUF     = 3,
    parameter logic [NUM_CH-1:0][31:0] CH_X_OFF = DEF_X_OFF,
    parameter logic [NUM_CH-1:0][31:0] CH_Y_OFF = DEF_Y_OFF,
    parameter logic [NUM_CH-1:0][31:0] CH_HSIZE = DEF_HSIZE,
    parameter logic [NUM_CH-1:0][31:0] CH_VSIZE = DEF_VSIZE
) (
    input  logic                       M_AXI_ACLK,
    input  logic                       M_AXI_ARESETN,
    input  logic [NUM_CH-1:0]          ch_frame_start,
    input  logic [NUM_CH-1:0]          ch_burst_rdy,
    output logic [NUM_CH-1:0]          ch_grant,
    output logic                       wr_req,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic                       wr_ack,
    input  logic                       wr_done,
    output logic [$clog2(NUM_BUF)-1:0] wr_buf_idx,
    output logic [$clog2(NUM_BUF)-1:0] rd_buf_idx,
    output logic                       rd_valid,
    output logic                       frame_done,
    output logic [NUM_CH-1:0]          ch_resync
);

    localparam int unsigned IW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BW            = $clog2(NUM_BUF);
    localparam int unsigned PIX_PER_BURST = BURST_LEN * DATA_WIDTH / 32;

    state_t state, state_nx;

    logic [NUM_CH-1:0] active, active_nx, pending, pending_nx, done, done_nx;
    logic [NUM_CH-1:0] resync_pend, resync_pend_nx, ch_resync_nx;
    logic [CNT_W-1:0]  burst_cnt [NUM_CH];
    logic [CNT_W-1:0]  line_cnt  [NUM_CH];
    logic [CNT_W-1:0]  burst_nx  [NUM_CH];
    logic [CNT_W-1:0]  line_nx   [NUM_CH];

    logic [NUM_CH-1:0] eligible, arb_gnt;
    logic [IW-1:0]     arb_idx, cur_idx;
    logic              start_grant, burst_fin, rotate, owned;

    assign eligible    = active & ch_burst_rdy;
    assign start_grant = (state == ST_IDLE) && (|eligible);
    assign burst_fin   = (state == ST_BUSY) && wr_done;
    assign wr_req      = (state == ST_REQ);

    stitch_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .req     (eligible),
        .upd     (burst_fin),
        .upd_idx (cur_idx),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) state <= ST_IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (|eligible) state_nx = ST_REQ;
            ST_REQ:  if (wr_ack)    state_nx = ST_BUSY;
            ST_BUSY: if (wr_done)   state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            ch_grant <= '0;
            cur_idx  <= '0;
            wr_addr  <= '0;
        end else if (start_grant) begin
            ch_grant <= arb_gnt;
            cur_idx  <= arb_idx;
            wr_addr  <= ADDR_WIDTH'(burst_addr(64'(BASE_ADDR), 64'(FRAME_BYTES),
                            64'(LINE_STRIDE), 64'(wr_buf_idx),
                            64'(CH_Y_OFF[arb_idx]) + 64'(line_cnt[arb_idx]),
                            64'(CH_X_OFF[arb_idx]) + 64'(burst_cnt[arb_idx]) * 64'(PIX_PER_BURST)));
        end else if (burst_fin) begin
            ch_grant <= '0;
        end
    end

    always_comb begin
        active_nx      = active;
        pending_nx     = pending;
        done_nx        = done;
        resync_pend_nx = resync_pend;
        ch_resync_nx   = ch_resync;
        owned          = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            burst_nx[c] = burst_cnt[c];
            line_nx[c]  = line_cnt[c];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            // A channel owns the burst from the grant decision until its wr_done.
            owned = (state == ST_IDLE) ? (start_grant && (arb_idx == IW'(c)))
                                       : (cur_idx == IW'(c));
            if (burst_fin && owned) begin
                if (resync_pend[c] || ch_frame_start[c]) begin
                    burst_nx[c]       = '0;
                    line_nx[c]        = '0;
                    resync_pend_nx[c] = 1'b0;
                    if (ch_frame_start[c]) ch_resync_nx[c] = 1'b1;
                end else if (burst_cnt[c] == CNT_W'(CH_HSIZE[c] / PIX_PER_BURST - 1)) begin
                    burst_nx[c] = '0;
                    if (line_cnt[c] == CNT_W'(CH_VSIZE[c] - 1)) begin
                        line_nx[c]   = '0;
                        active_nx[c] = 1'b0;
                        done_nx[c]   = 1'b1;
                    end else begin
                        line_nx[c] = line_cnt[c] + 1'b1;
                    end
                end else begin
                    burst_nx[c] = burst_cnt[c] + 1'b1;
                end
            end else if (ch_frame_start[c]) begin
                if (active[c]) begin
                    ch_resync_nx[c] = 1'b1;
                    if (owned && (state != ST_IDLE || start_grant)) begin
                        resync_pend_nx[c] = 1'b1;
                    end else begin
                        burst_nx[c] = '0;
                        line_nx[c]  = '0;
                    end
                end else if (done[c]) begin
                    pending_nx[c] = 1'b1;
                end else begin
                    active_nx[c] = 1'b1;
                    burst_nx[c]  = '0;
                    line_nx[c]   = '0;
                end
            end
        end
        rotate = burst_fin && (&done_nx);
        if (rotate) begin
            done_nx    = '0;
            active_nx  = active_nx | pending_nx;
            pending_nx = '0;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            active      <= '0;
            pending     <= '0;
            done        <= '0;
            resync_pend <= '0;
            ch_resync   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                burst_cnt[c] <= '0;
                line_cnt[c]  <= '0;
            end
            wr_buf_idx  <= '0;
            rd_buf_idx  <= '0;
            rd_valid    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            active      <= active_nx;
            pending     <= pending_nx;
            done        <= done_nx;
            resync_pend <= resync_pend_nx;
            ch_resync   <= ch_resync_nx;
            for (int c = 0; c < NUM_CH; c++) begin
                burst_cnt[c] <= burst_nx[c];
                line_cnt[c]  <= line_nx[c];
            end
            frame_done <= rotate;
            if (rotate) begin
                wr_buf_idx <= (wr_buf_idx == BW'(NUM_BUF - 1)) ? '0 : wr_buf_idx + 1'b1;
                rd_buf_idx <= wr_buf_idx;
                rd_valid   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stitch_wr_scheduler.sv
//==== tb_stitch_wr_scheduler: directed vector bench for the stitching write scheduler ====
//==== Rev 1.0 ====
`default_nettype none

module tb_stitch_wr_scheduler;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  ch_frame_start, ch_burst_rdy, ch_grant, ch_resync;
    logic        wr_req, wr_ack, wr_done, rd_valid, frame_done;
    logic [31:0] wr_addr;
    logic [1:0]  wr_buf_idx, rd_buf_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Small tiles (2 bursts wide, 4/2/2 lines) keep a full frame to 16 bursts.
    stitch_wr_scheduler #(
        .CH_HSIZE ({32'd128, 32'd128, 32'd128}),
        .CH_VSIZE ({32'd2,   32'd2,   32'd4})
    ) dut (
        .M_AXI_ACLK     (clk),
        .M_AXI_ARESETN  (rstn),
        .ch_frame_start (ch_frame_start),
        .ch_burst_rdy   (ch_burst_rdy),
        .ch_grant       (ch_grant),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_ack         (wr_ack),
        .wr_done        (wr_done),
        .wr_buf_idx     (wr_buf_idx),
        .rd_buf_idx     (rd_buf_idx),
        .rd_valid       (rd_valid),
        .frame_done     (frame_done),
        .ch_resync      (ch_resync)
    );

    typedef struct {
        logic [2:0]  rdy;
        logic [2:0]  gnt;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_wr_req",   {63'd0, wr_req},     64'd0);
        check("rst_grant",    {61'd0, ch_grant},   64'd0);
        check("rst_addr",     {32'd0, wr_addr},    64'd0);
        check("rst_wr_buf",   {62'd0, wr_buf_idx}, 64'd0);
        check("rst_rd_buf",   {62'd0, rd_buf_idx}, 64'd0);
        check("rst_rd_valid", {63'd0, rd_valid},   64'd0);
        check("rst_fdone",    {63'd0, frame_done}, 64'd0);
        check("rst_resync",   {61'd0, ch_resync},  64'd0);
    endtask

    task automatic pulse_fs(input logic [2:0] mask);
        ch_frame_start = mask;
        @(negedge clk);
        ch_frame_start = 3'b000;
    endtask

    // One burst handshake; optionally pulses frame_start while BUSY or stops in BUSY.
    task automatic serve(input logic [2:0] rdy, input logic [2:0] exp_gnt,
                         input logic [31:0] exp_addr, input bit chk,
                         input logic [2:0] fs_busy, input bit stop_in_busy);
        int n;
        ch_burst_rdy = rdy;
        @(negedge clk);
        n = 1;
        while (!wr_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", {63'd0, wr_req}, 64'd1);
        if (!wr_req) begin
            ch_burst_rdy = 3'b000;
            return;
        end
        if (chk) begin
            check("grant", {61'd0, ch_grant}, {61'd0, exp_gnt});
            check("addr",  {32'd0, wr_addr},  {32'd0, exp_addr});
        end
        @(negedge clk);
        if (chk) check("addr_hold", {32'd0, wr_addr}, {32'd0, exp_addr});
        wr_ack       = 1'b1;
        ch_burst_rdy = 3'b000;
        @(negedge clk);
        wr_ack = 1'b0;
        check("req_drop", {63'd0, wr_req}, 64'd0);
        ch_frame_start = fs_busy;
        @(negedge clk);
        ch_frame_start = 3'b000;
        if (stop_in_busy) return;
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
    endtask

    task automatic run_frame(input logic [2:0] rdy);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            serve(rdy, 3'b000, 32'h0, 1'b0, 3'b000, 1'b0);
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_seen", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{3'b001, 3'b001, 32'h1000_0000};
        vecs[1]  = '{3'b010, 3'b010, 32'h1000_0F00};
        vecs[2]  = '{3'b100, 3'b100, 32'h103F_5700};
        vecs[3]  = '{3'b111, 3'b001, 32'h1000_0100};
        vecs[4]  = '{3'b111, 3'b010, 32'h1000_1000};
        vecs[5]  = '{3'b111, 3'b100, 32'h103F_5800};
        vecs[6]  = '{3'b111, 3'b001, 32'h1000_1E00};
        vecs[7]  = '{3'b111, 3'b010, 32'h1000_2D00};
        vecs[8]  = '{3'b101, 3'b100, 32'h103F_7500};
        vecs[9]  = '{3'b110, 3'b010, 32'h1000_2E00};
        vecs[10] = '{3'b111, 3'b100, 32'h103F_7600};
        vecs[11] = '{3'b111, 3'b001, 32'h1000_1F00};
        vecs[12] = '{3'b111, 3'b001, 32'h1000_3C00};
        vecs[13] = '{3'b111, 3'b001, 32'h1000_3D00};
        vecs[14] = '{3'b111, 3'b001, 32'h1000_5A00};
        vecs[15] = '{3'b111, 3'b001, 32'h1000_5B00};

        rstn = 1'b0;
        ch_frame_start = 3'b000;
        ch_burst_rdy   = 3'b000;
        wr_ack  = 1'b0;
        wr_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        rstn = 1'b1;

        // Frame 1 into buffer 0
        pulse_fs(3'b111);
        for (int i = 0; i < 16; i++) begin
            serve(vecs[i].rdy, vecs[i].gnt, vecs[i].addr, 1'b1, 3'b000, 1'b0);
        end
        check("f1_frame_done", {63'd0, frame_done}, 64'd1);
        check("f1_wr_buf",     {62'd0, wr_buf_idx}, 64'd1);
        check("f1_rd_buf",     {62'd0, rd_buf_idx}, 64'd0);
        check("f1_rd_valid",   {63'd0, rd_valid},   64'd1);
        @(negedge clk);
        check("f1_pulse_end",  {63'd0, frame_done}, 64'd0);

        // Frames 2 and 3
        pulse_fs(3'b111);
        serve(3'b001, 3'b001, 32'h107E_9000, 1'b1, 3'b000, 1'b0);
        run_frame(3'b111);
        check("f2_wr_buf", {62'd0, wr_buf_idx}, 64'd2);
        check("f2_rd_buf", {62'd0, rd_buf_idx}, 64'd1);
        pulse_fs(3'b111);
        run_frame(3'b111);
        check("f3_wr_buf", {62'd0, wr_buf_idx}, 64'd0);
        check("f3_rd_buf", {62'd0, rd_buf_idx}, 64'd2);

        // Frame 4 in buffer 0: mid-frame resync of ch1
        pulse_fs(3'b111);
        serve(3'b010, 3'b010, 32'h1000_0F00, 1'b1, 3'b000, 1'b0);
        serve(3'b010, 3'b010, 32'h1000_1000, 1'b1, 3'b000, 1'b0);
        serve(3'b001, 3'b001, 32'h1000_0000, 1'b1, 3'b000, 1'b0);
        pulse_fs(3'b010);
        check("resync_flag", {61'd0, ch_resync}, 64'h2);
        serve(3'b010, 3'b010, 32'h1000_0F00, 1'b1, 3'b000, 1'b0);
        serve(3'b010, 3'b010, 32'h1000_1000, 1'b1, 3'b010, 1'b0);
        serve(3'b010, 3'b010, 32'h1000_0F00, 1'b1, 3'b000, 1'b0);
        serve(3'b001, 3'b001, 32'h1000_0100, 1'b1, 3'b000, 1'b0);

        // Finish ch1 and ch2, queue ch1's next frame, then let ch0 close the frame
        for (int i = 0; i < 3; i++) serve(3'b010, 3'b000, 32'h0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) serve(3'b100, 3'b000, 32'h0, 1'b0, 3'b000, 1'b0);
        pulse_fs(3'b010);
        run_frame(3'b001);
        check("f4_wr_buf", {62'd0, wr_buf_idx}, 64'd1);
        check("f4_rd_buf", {62'd0, rd_buf_idx}, 64'd0);
        serve(3'b010, 3'b010, 32'h107E_9F00, 1'b1, 3'b000, 1'b0);

        // Reset while BUSY; a late wr_done must be ignored
        serve(3'b010, 3'b000, 32'h0, 1'b0, 3'b000, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_state();
        rstn    = 1'b1;
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        @(negedge clk);
        check("post_rst_req",   {63'd0, wr_req},   64'd0);
        check("post_rst_grant", {61'd0, ch_grant}, 64'd0);
        pulse_fs(3'b111);
        serve(3'b001, 3'b001, 32'h1000_0000, 1'b1, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
